// File: rtl/sawtooth_key_extractor_pkg.sv
// Shared definitions for the sawtooth keystream extractor: FSM states,
// FP32 exponent field constants and the key-whitening LFSR parameters.
package saw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_EXTRACT = 2'd3
    } state_e;

    // FP32 exponent field position and the two reserved encodings
    localparam int         EXP_MSB  = 30;
    localparam int         EXP_LSB  = 23;
    localparam logic [7:0] EXP_ALL0 = 8'h00;
    localparam logic [7:0] EXP_ALL1 = 8'hFF;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Zero/denormal or Inf/NaN samples cannot seed another iteration
    function automatic logic is_degenerate(input logic [7:0] exp_field);
        return (exp_field == EXP_ALL0) || (exp_field == EXP_ALL1);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sawtooth_key_extractor_key_fifo.sv
// Key-byte FIFO: circular buffer with a two-byte push port (hi ahead of lo)
// and a one-byte pop port. The head byte is read combinationally.
module key_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [7:0]             push_hi_i,
    input  logic [7:0]             push_lo_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [7:0]             head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_nxt;
    logic          pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign wr_nxt  = wr_q + AW'(1);
    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_q] : 8'h00;
    assign count_o = count_q;

    // Byte storage: both pushed bytes land in consecutive slots
    // NOTE: the storage array is not reset; count_q gates validity, so stale contents never reach head_o.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q]   <= push_hi_i;
            mem_q[wr_nxt] <= push_lo_i;
        end
    end

    // Pointers wrap naturally; count tracks occupancy with push and pop both honoured
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(2);
            if (pop_ok) rd_q <= rd_q + AW'(1);
            case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + CW'(2);
                2'b01:   count_q <= count_q - CW'(1);
                2'b11:   count_q <= count_q + CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sawtooth_key_extractor.sv
// Iteration controller and keystream source: seeds the sawtooth map core,
// feeds each result back as the next operand and slices the low mantissa
// bytes of every sample into the key FIFO.
// Optional build macro KEY_WHITEN_EN: XOR each pushed byte with an 8-bit LFSR.
module sawtooth_key_extractor
    import saw_pkg::*;
#(
    parameter int PRECISION  = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [PRECISION-1:0] seed,
    input  logic [PRECISION-1:0] epsilon,
    output logic                 saw_start,
    output logic [PRECISION-1:0] saw_x,
    output logic [PRECISION-1:0] saw_eps,
    input  logic                 saw_done,
    input  logic [PRECISION-1:0] saw_result,
    output logic                 key_valid,
    output logic [7:0]           key_byte,
    input  logic                 key_ready,
    output logic                 busy,
    output logic                 err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                 state_q;
    state_e                 state_d;
    logic [PRECISION-1:0]   x_q;
    logic [PRECISION-1:0]   eps_q;
    logic                   err_q;
    logic [CW-1:0]          fifo_count;
    logic                   space_ok;
    logic                   degenerate;
    logic                   push_en;
    logic                   pop_en;
    logic [7:0]             push_hi;
    logic [7:0]             push_lo;

    // Space for a byte pair is judged on the pre-pop count
    assign space_ok   = (fifo_count <= CW'(FIFO_DEPTH - 2));
    assign degenerate = is_degenerate(saw_result[EXP_MSB:EXP_LSB]);
    assign pop_en     = key_valid && key_ready;

    assign saw_x   = x_q;
    assign saw_eps = eps_q;
    assign err     = err_q;

    // State register
    // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    // NOTE: state_d takes a default first so no branch leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT:    if (saw_done) state_d = degenerate ? ST_IDLE : ST_EXTRACT;
            ST_EXTRACT: if (space_ok) state_d = stop ? ST_IDLE : ST_ISSUE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode: request pulse, push strobe and busy flag
    always_comb begin
        saw_start = 1'b0;
        push_en   = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_ISSUE:   saw_start = 1'b1;
            ST_EXTRACT: push_en   = space_ok;
            default:    ;
        endcase
    end

    // Operand, parameter and error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            eps_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                x_q   <= seed;
                eps_q <= epsilon;
                err_q <= 1'b0;
            end
            if (state_q == ST_WAIT && saw_done) begin
                x_q <= saw_result;
                if (degenerate) err_q <= 1'b1;
            end
        end
    end

`ifdef KEY_WHITEN_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_mid;

    assign lfsr_mid = lfsr_step(lfsr_q);
    assign push_hi  = x_q[15:8] ^ lfsr_q;
    assign push_lo  = x_q[7:0]  ^ lfsr_mid;

    // Whitening LFSR: reseeded per session, two steps per byte pair
    always_ff @(posedge clk) begin
        if (reset)                         lfsr_q <= LFSR_SEED;
        else if (state_q == ST_IDLE && start) lfsr_q <= LFSR_SEED;
        else if (push_en)                  lfsr_q <= lfsr_step(lfsr_mid);
    end
`else
    assign push_hi = x_q[15:8];
    assign push_lo = x_q[7:0];
`endif

    key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push_en),
        .push_hi_i (push_hi),
        .push_lo_i (push_lo),
        .pop_i     (pop_en),
        .valid_o   (key_valid),
        .head_o    (key_byte),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_sawtooth_key_extractor.sv
// Directed bench for sawtooth_key_extractor with a behavioural sawtooth core
// responder and a byte collector on the key output.
module tb_sawtooth_key_extractor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] seed;
    logic [31:0] epsilon;
    logic        saw_start;
    logic [31:0] saw_x;
    logic [31:0] saw_eps;
    logic        saw_done;
    logic [31:0] saw_result;
    logic        key_valid;
    logic [7:0]  key_byte;
    logic        key_ready;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    // core responder configuration
    int          core_lat = 4;
    logic        stray_en = 1'b0;
    logic [31:0] resp [64];
    int          resp_wr = 0;
    int          resp_rd;

    logic [31:0] sx_log [$];
    logic [7:0]  got [$];
    logic [7:0]  wl;
    int          base_s;
    int          base_b;

    always #5 clk = ~clk;

    sawtooth_key_extractor dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .seed       (seed),
        .epsilon    (epsilon),
        .saw_start  (saw_start),
        .saw_x      (saw_x),
        .saw_eps    (saw_eps),
        .saw_done   (saw_done),
        .saw_result (saw_result),
        .key_valid  (key_valid),
        .key_byte   (key_byte),
        .key_ready  (key_ready),
        .busy       (busy),
        .err        (err)
    );

    // Sawtooth core model: done pulse core_lat cycles after each request
    initial begin : core_model
        int cnt;
        cnt        = 0;
        resp_rd    = 0;
        saw_done   = 1'b0;
        saw_result = '0;
        forever begin
            @(negedge clk);
            saw_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    saw_done   = 1'b1;
                    saw_result = resp[resp_rd % 64];
                    resp_rd++;
                end
            end else if (saw_start === 1'b1) begin
                cnt = core_lat;
            end
            if (stray_en) begin
                saw_done   = 1'b1;
                saw_result = 32'h3F80_1111;
            end
        end
    end

    // Observe requests and accepted key bytes on the falling edge
    always @(negedge clk) begin
        if (saw_start === 1'b1) sx_log.push_back(saw_x);
        if (key_valid === 1'b1 && key_ready === 1'b1) got.push_back(key_byte);
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [7:0] lfsr_nx(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] e);
        seed    = s;
        epsilon = e;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic load_resp(input logic [31:0] r);
        resp[resp_wr % 64] = r;
        resp_wr++;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 300) begin
            tick();
            k++;
        end
        check(tag, {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_starts(input int target, input string tag);
        int k;
        k = 0;
        while (sx_log.size() < target && k < 300) begin
            tick();
            k++;
        end
        check(tag, sx_log.size(), target);
    endtask

    // Compare one collected byte with the raw sample byte (whitened when enabled)
    task automatic check_byte(input string tag, input int idx, input logic [7:0] raw);
        logic [7:0] exp_b;
        logic [7:0] act_b;
`ifdef KEY_WHITEN_EN
        exp_b = raw ^ wl;
        wl    = lfsr_nx(wl);
`else
        exp_b = raw;
`endif
        act_b = (idx < got.size()) ? got[idx] : 8'hxx;
        check(tag, {24'h0, act_b}, {24'h0, exp_b});
    endtask

    initial begin : stimulus
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        seed      = '0;
        epsilon   = '0;
        key_ready = 1'b0;
        wl        = 8'hA5;
        tick(3);
        reset = 1'b0;
        tick();

        // ---- reset state, then idle with stray done pulses ----
        check("rst_saw_start", {31'h0, saw_start}, 32'h0);
        check("rst_saw_x",     saw_x,              32'h0);
        check("rst_saw_eps",   saw_eps,            32'h0);
        check("rst_key_valid", {31'h0, key_valid}, 32'h0);
        check("rst_key_byte",  {24'h0, key_byte},  32'h0);
        check("rst_busy",      {31'h0, busy},      32'h0);
        check("rst_err",       {31'h0, err},       32'h0);
        stray_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", {29'h0, key_valid, busy, saw_start}, 32'h0);
        end
        stray_en = 1'b0;
        tick(2);

        // ---- single sample, stop raised at start ----
        core_lat  = 12;
        key_ready = 1'b1;
        stop      = 1'b1;
        load_resp(32'h3F8F_C265);
        base_s = sx_log.size();
        base_b = got.size();
        pulse_start(32'h3FE0_0000, 32'h3D4C_CCCD);
        check("s2_issue_lat", {31'h0, saw_start}, 32'h1);
        check("s2_saw_x",     saw_x,   32'h3FE0_0000);
        check("s2_saw_eps",   saw_eps, 32'h3D4C_CCCD);
        wait_idle("s2_idle");
        tick(2);
        check("s2_starts", sx_log.size() - base_s, 1);
        check("s2_nbytes", got.size() - base_b, 2);
        wl = 8'hA5;
        check_byte("s2_hi", base_b,     8'hC2);
        check_byte("s2_lo", base_b + 1, 8'h65);
        check("s2_err", {31'h0, err}, 32'h0);

        // ---- three iterations, result fed back, mid-session start ignored ----
        core_lat = 3;
        stop     = 1'b0;
        load_resp(32'h4049_0FDB);
        load_resp(32'h3F35_04F3);
        load_resp(32'h3E8A_3D71);
        base_s = sx_log.size();
        base_b = got.size();
        pulse_start(32'h3FC0_0000, 32'h3E00_0000);
        wait_starts(base_s + 2, "s3_second_issue");
        pulse_start(32'hDEAD_BEEF, 32'h1234_5678);
        wait_starts(base_s + 3, "s3_third_issue");
        stop = 1'b1;
        wait_idle("s3_idle");
        tick(2);
        check("s3_starts", sx_log.size() - base_s, 3);
        check("s3_x0", sx_log[base_s],     32'h3FC0_0000);
        check("s3_x1", sx_log[base_s + 1], 32'h4049_0FDB);
        check("s3_x2", sx_log[base_s + 2], 32'h3F35_04F3);
        check("s3_eps_held", saw_eps, 32'h3E00_0000);
        check("s3_nbytes", got.size() - base_b, 6);
        wl = 8'hA5;
        check_byte("s3_b0", base_b,     8'h0F);
        check_byte("s3_b1", base_b + 1, 8'hDB);
        check_byte("s3_b2", base_b + 2, 8'h04);
        check_byte("s3_b3", base_b + 3, 8'hF3);
        check_byte("s3_b4", base_b + 4, 8'h3D);
        check_byte("s3_b5", base_b + 5, 8'h71);

        // ---- back-pressure: FIFO full stalls EXTRACT ----
        core_lat  = 2;
        stop      = 1'b0;
        key_ready = 1'b0;
        load_resp(32'h3F80_0001);
        load_resp(32'h3F80_1234);
        load_resp(32'h3F80_ABCD);
        load_resp(32'h3F80_5A5A);
        load_resp(32'h3F80_FF00);
        base_s = sx_log.size();
        base_b = got.size();
        pulse_start(32'h3F80_0000, 32'h3E00_0000);
        wait_starts(base_s + 5, "s4_fifth_issue");
        tick(20);
        check("s4_stall_starts", sx_log.size() - base_s, 5);
        check("s4_stall_busy",   {31'h0, busy},      32'h1);
        check("s4_stall_valid",  {31'h0, key_valid}, 32'h1);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        tick(6);
        check("s4_one_pop_starts", sx_log.size() - base_s, 5);
        check("s4_one_pop_busy",   {31'h0, busy}, 32'h1);
        check("s4_one_pop_nbytes", got.size() - base_b, 1);
        stop      = 1'b1;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        wait_idle("s4_release");
        check("s4_release_starts", sx_log.size() - base_s, 5);
        key_ready = 1'b1;
        tick(12);
        key_ready = 1'b0;
        check("s4_nbytes", got.size() - base_b, 10);
        check("s4_drained", {31'h0, key_valid}, 32'h0);
        wl = 8'hA5;
        check_byte("s4_b0", base_b,     8'h00);
        check_byte("s4_b1", base_b + 1, 8'h01);
        check_byte("s4_b2", base_b + 2, 8'h12);
        check_byte("s4_b3", base_b + 3, 8'h34);
        check_byte("s4_b4", base_b + 4, 8'hAB);
        check_byte("s4_b5", base_b + 5, 8'hCD);
        check_byte("s4_b6", base_b + 6, 8'h5A);
        check_byte("s4_b7", base_b + 7, 8'h5A);
        check_byte("s4_b8", base_b + 8, 8'hFF);
        check_byte("s4_b9", base_b + 9, 8'h00);

        // ---- degenerate samples set err, next start clears it ----
        core_lat  = 4;
        stop      = 1'b0;
        key_ready = 1'b1;
        load_resp(32'h7FC0_0000);
        base_s = sx_log.size();
        base_b = got.size();
        pulse_start(32'h3FE0_0000, 32'h3D4C_CCCD);
        wait_idle("s5_nan_idle");
        tick(2);
        check("s5_nan_err",    {31'h0, err},       32'h1);
        check("s5_nan_valid",  {31'h0, key_valid}, 32'h0);
        check("s5_nan_nbytes", got.size() - base_b, 0);
        check("s5_nan_starts", sx_log.size() - base_s, 1);
        stop = 1'b1;
        load_resp(32'h3F80_0102);
        base_b = got.size();
        pulse_start(32'h3FE0_0000, 32'h3D4C_CCCD);
        check("s5_err_clear", {31'h0, err}, 32'h0);
        wait_idle("s5_ok_idle");
        tick(2);
        wl = 8'hA5;
        check_byte("s5_hi", base_b,     8'h01);
        check_byte("s5_lo", base_b + 1, 8'h02);
        stop = 1'b0;
        load_resp(32'h0040_0000);
        base_b = got.size();
        pulse_start(32'h3FE0_0000, 32'h3D4C_CCCD);
        wait_idle("s5_den_idle");
        tick(2);
        check("s5_den_err",    {31'h0, err}, 32'h1);
        check("s5_den_nbytes", got.size() - base_b, 0);

        // ---- reset during WAIT, late done ignored ----
        core_lat = 10;
        stop     = 1'b0;
        load_resp(32'h3F80_AAAA);
        base_s = sx_log.size();
        base_b = got.size();
        pulse_start(32'h3FE0_0000, 32'h3D4C_CCCD);
        tick(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(15);
        check("s6_starts", sx_log.size() - base_s, 1);
        check("s6_busy",   {31'h0, busy},      32'h0);
        check("s6_valid",  {31'h0, key_valid}, 32'h0);
        check("s6_nbytes", got.size() - base_b, 0);
        check("s6_err",    {31'h0, err},       32'h0);
        check("s6_saw_x",  saw_x,              32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
